ipselector_ipselector_cpu_ocimem: RTL and testbench

IPSELECTOR_IPSELECTOR_CPU_OCIMEM -- requirements
Module: ipselector_ipselector_cpu_ocimem

---
 rtl/ipselector_ipselector_cpu_ocimem_pkg.sv | 23 ++
 rtl/ipselector_ipselector_cpu_ociram_sp.sv | 34 +++
 rtl/ipselector_ipselector_cpu_ocimem.sv | 149 ++++++++++++++
 tb/tb_ipselector_ipselector_cpu_ocimem.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/ipselector_ipselector_cpu_ocimem_pkg.sv
// Shared types and JTAG debug-word field positions for the OCI debug memory.
package ipselector_ipselector_cpu_ocimem_pkg;

   localparam int unsigned JDO_W       = 38;
   localparam int unsigned DATA_W      = 32;
   localparam int unsigned BE_W        = 4;

   // jdo field positions; the address field sits inside the data field,
   // so a given strobe only interprets the fields that belong to it.
   localparam int unsigned JDO_RD_BIT  = 35;
   localparam int unsigned JDO_DATA_HI = 34;
   localparam int unsigned JDO_DATA_LO = 3;
   localparam int unsigned JDO_ADDR_HI = 33;
   localparam int unsigned JDO_ADDR_LO = 26;

   typedef enum logic [1:0] {
      ST_IDLE       = 2'd0,
      ST_RD_ISSUE   = 2'd1,
      ST_RD_CAPTURE = 2'd2,
      ST_WR_ISSUE   = 2'd3
   } ocimem_state_e;

endpackage

// File: rtl/ipselector_ipselector_cpu_ociram_sp.sv
// Single-port 32-bit RAM with byte enables and a registered one-cycle read.
module ipselector_ipselector_cpu_ociram_sp
   import ipselector_ipselector_cpu_ocimem_pkg::*;
#(
   parameter int unsigned ADDR_W = 8
) (
   input  logic              clk,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic              wren_i,
   input  logic [BE_W-1:0]   byteenable_i,
   input  logic [DATA_W-1:0] wdata_i,
   output logic [DATA_W-1:0] q_o
);

   localparam int unsigned DEPTH = 2**ADDR_W;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] q_q;

   // Byte-lane writes; read returns pre-write contents one cycle later.
   always_ff @(posedge clk) begin
      if (wren_i) begin
         for (int b = 0; b < int'(BE_W); b++) begin
            if (byteenable_i[b]) begin
               mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
         end
      end
      q_q <= mem_q[addr_i];
   end

   assign q_o = q_q;

endmodule

// File: rtl/ipselector_ipselector_cpu_ocimem.sv
// OCI debug memory: JTAG-driven debug FSM sharing a single-port RAM with the CPU.
module ipselector_ipselector_cpu_ocimem
   import ipselector_ipselector_cpu_ocimem_pkg::*;
#(
   parameter int unsigned ADDR_W = 8
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [JDO_W-1:0]  jdo,
   input  logic              take_action_ocimem_a,
   input  logic              take_action_ocimem_b,
   input  logic              take_no_action_ocimem_a,
   input  logic [ADDR_W-1:0] cpu_address,
   input  logic              cpu_read,
   input  logic              cpu_write,
   input  logic [DATA_W-1:0] cpu_writedata,
   input  logic [BE_W-1:0]   cpu_byteenable,
   output logic [DATA_W-1:0] cpu_readdata,
   output logic              cpu_waitrequest,
   output logic [DATA_W-1:0] MonDReg,
   output logic              ocimem_busy,
   output logic              ocimem_overrun
);

   ocimem_state_e     state_q;
   logic [ADDR_W-1:0] mon_a_q;
   logic [DATA_W-1:0] mon_d_q;
   logic              overrun_q;
   logic              rd_pending_q, rd_pending_d;
   logic [DATA_W-1:0] rdata_hold_q;

   logic              debug_owns;
   logic              cpu_wr_grant;
   logic              any_strobe;
   logic [ADDR_W-1:0] ram_addr;
   logic              ram_wren;
   logic [BE_W-1:0]   ram_be;
   logic [DATA_W-1:0] ram_wdata;
   logic [DATA_W-1:0] ram_q;

   // Bits of jdo this block never interprets.
   logic unused_jdo;
   assign unused_jdo = ^{jdo[JDO_W-1:JDO_RD_BIT+1], jdo[JDO_DATA_LO-1:0]};

   assign any_strobe = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
   assign debug_owns = (state_q == ST_RD_ISSUE) || (state_q == ST_WR_ISSUE);

   // Debug FSM: address/data registers, sticky overrun on strobes dropped while busy.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q   <= ST_IDLE;
         mon_a_q   <= '0;
         mon_d_q   <= '0;
         overrun_q <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (take_action_ocimem_a) begin
                  mon_a_q   <= ADDR_W'(jdo[JDO_ADDR_HI:JDO_ADDR_LO]);
                  overrun_q <= 1'b0;
                  if (jdo[JDO_RD_BIT]) state_q <= ST_RD_ISSUE;
               end else if (take_action_ocimem_b) begin
                  mon_d_q <= jdo[JDO_DATA_HI:JDO_DATA_LO];
                  state_q <= ST_WR_ISSUE;
               end else if (take_no_action_ocimem_a) begin
                  state_q <= ST_RD_ISSUE;
               end
            end
            ST_RD_ISSUE: begin
               if (any_strobe) overrun_q <= 1'b1;
               state_q <= ST_RD_CAPTURE;
            end
            ST_RD_CAPTURE: begin
               if (any_strobe) overrun_q <= 1'b1;
               mon_d_q <= ram_q;
               mon_a_q <= mon_a_q + ADDR_W'(1);
               state_q <= ST_IDLE;
            end
            ST_WR_ISSUE: begin
               if (any_strobe) overrun_q <= 1'b1;
               mon_a_q <= mon_a_q + ADDR_W'(1);
               state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   // CPU arbitration and RAM port mux; the read-return cycle needs no port.
   always_comb begin
      rd_pending_d    = 1'b0;
      cpu_wr_grant    = 1'b0;
      cpu_waitrequest = 1'b0;
      if (rd_pending_q) begin
         cpu_waitrequest = 1'b0;
      end else if (cpu_read || cpu_write) begin
         if (!debug_owns && reset_n) begin
            if (cpu_write) begin
               cpu_wr_grant = 1'b1;
            end else begin
               cpu_waitrequest = 1'b1;
               rd_pending_d    = 1'b1;
            end
         end else begin
            cpu_waitrequest = 1'b1;
         end
      end

      if (debug_owns) begin
         ram_addr  = mon_a_q;
         ram_wren  = reset_n && (state_q == ST_WR_ISSUE);
         ram_be    = '1;
         ram_wdata = mon_d_q;
      end else begin
         ram_addr  = cpu_address;
         ram_wren  = cpu_wr_grant;
         ram_be    = cpu_byteenable;
         ram_wdata = cpu_writedata;
      end
   end

   // CPU read-return tracking; readdata holds the last returned word.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         rd_pending_q <= 1'b0;
         rdata_hold_q <= '0;
      end else begin
         rd_pending_q <= rd_pending_d;
         if (rd_pending_q) rdata_hold_q <= ram_q;
      end
   end

   ipselector_ipselector_cpu_ociram_sp #(
      .ADDR_W(ADDR_W)
   ) u_ram (
      .clk         (clk),
      .addr_i      (ram_addr),
      .wren_i      (ram_wren),
      .byteenable_i(ram_be),
      .wdata_i     (ram_wdata),
      .q_o         (ram_q)
   );

   assign cpu_readdata   = rd_pending_q ? ram_q : rdata_hold_q;
   assign MonDReg        = mon_d_q;
   assign ocimem_busy    = (state_q != ST_IDLE);
   assign ocimem_overrun = overrun_q;

endmodule

// File: tb/tb_ipselector_ipselector_cpu_ocimem.sv
// Directed bench for the OCI debug memory: debug read/write, wrap, overrun, CPU arbitration, reset.
module tb_ipselector_ipselector_cpu_ocimem;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [37:0] jdo;
   logic        take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a;
   logic [7:0]  cpu_address;
   logic        cpu_read, cpu_write;
   logic [31:0] cpu_writedata;
   logic [3:0]  cpu_byteenable;
   logic [31:0] cpu_readdata;
   logic        cpu_waitrequest;
   logic [31:0] MonDReg;
   logic        ocimem_busy, ocimem_overrun;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   ipselector_ipselector_cpu_ocimem #(.ADDR_W(8)) dut (
      .clk                    (clk),
      .reset_n                (reset_n),
      .jdo                    (jdo),
      .take_action_ocimem_a   (take_action_ocimem_a),
      .take_action_ocimem_b   (take_action_ocimem_b),
      .take_no_action_ocimem_a(take_no_action_ocimem_a),
      .cpu_address            (cpu_address),
      .cpu_read               (cpu_read),
      .cpu_write              (cpu_write),
      .cpu_writedata          (cpu_writedata),
      .cpu_byteenable         (cpu_byteenable),
      .cpu_readdata           (cpu_readdata),
      .cpu_waitrequest        (cpu_waitrequest),
      .MonDReg                (MonDReg),
      .ocimem_busy            (ocimem_busy),
      .ocimem_overrun         (ocimem_overrun)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [37:0] jdo_a(input logic rd, input logic [7:0] addr);
      logic [37:0] j;
      j        = '0;
      j[35]    = rd;
      j[33:26] = addr;
      return j;
   endfunction

   function automatic logic [37:0] jdo_b(input logic [31:0] data);
      logic [37:0] j;
      j       = '0;
      j[34:3] = data;
      return j;
   endfunction

   // Inputs change just after the rising edge; checks happen at the falling edge.
   task automatic to_check();
      @(negedge clk);
   endtask

   task automatic next_cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic strobes(input logic a, input logic b, input logic na);
      take_action_ocimem_a    = a;
      take_action_ocimem_b    = b;
      take_no_action_ocimem_a = na;
   endtask

   initial begin
      reset_n = 1'b0;
      jdo = '0;
      strobes(0, 0, 0);
      cpu_address = '0; cpu_read = 0; cpu_write = 0;
      cpu_writedata = '0; cpu_byteenable = 4'hF;
      repeat (3) next_cyc();

      // Reset state
      to_check();
      chk("rst_busy", 32'(ocimem_busy), 32'd0);
      chk("rst_mond", MonDReg, 32'd0);
      chk("rst_overrun", 32'(ocimem_overrun), 32'd0);
      chk("rst_rdata", cpu_readdata, 32'd0);
      chk("rst_wait", 32'(cpu_waitrequest), 32'd0);
      next_cyc();
      reset_n = 1'b1;
      next_cyc();

      // Load address 0x10 without read, then write 0xDEADBEEF
      jdo = jdo_a(1'b0, 8'h10); strobes(1, 0, 0);
      next_cyc();
      strobes(0, 0, 0);
      to_check();
      chk("a_noread_busy", 32'(ocimem_busy), 32'd0);
      chk("a_addr", 32'(dut.mon_a_q), 32'h10);
      next_cyc();
      jdo = jdo_b(32'hDEADBEEF); strobes(0, 1, 0);
      next_cyc();
      strobes(0, 0, 0);
      to_check();
      chk("wr_busy", 32'(ocimem_busy), 32'd1);
      chk("wr_mond", MonDReg, 32'hDEADBEEF);
      next_cyc();
      to_check();
      chk("wr_done_busy", 32'(ocimem_busy), 32'd0);
      chk("wr_addr_inc", 32'(dut.mon_a_q), 32'h11);
      next_cyc();

      // Write 0x12345678 to 0x11; CPU read of 0x11 collides with WR_ISSUE
      jdo = jdo_b(32'h12345678); strobes(0, 1, 0);
      next_cyc();
      strobes(0, 0, 0);
      cpu_read = 1; cpu_address = 8'h11;
      to_check();
      chk("cpu_blocked_wait", 32'(cpu_waitrequest), 32'd1);
      next_cyc();
      to_check();
      chk("cpu_grant_wait", 32'(cpu_waitrequest), 32'd1);
      next_cyc();
      to_check();
      chk("cpu_ret_wait", 32'(cpu_waitrequest), 32'd0);
      chk("cpu_ret_data", cpu_readdata, 32'h12345678);
      next_cyc();
      cpu_read = 0;

      // Debug read of 0x10: busy for two cycles, data at t+3
      jdo = jdo_a(1'b1, 8'h10); strobes(1, 0, 0);
      next_cyc();
      strobes(0, 0, 0);
      to_check();
      chk("rd_busy_t1", 32'(ocimem_busy), 32'd1);
      next_cyc();
      to_check();
      chk("rd_busy_t2", 32'(ocimem_busy), 32'd1);
      chk("rd_mond_t2", MonDReg, 32'h12345678);
      next_cyc();
      to_check();
      chk("rd_busy_t3", 32'(ocimem_busy), 32'd0);
      chk("rd_mond_t3", MonDReg, 32'hDEADBEEF);
      chk("rd_addr_inc", 32'(dut.mon_a_q), 32'h11);
      next_cyc();

      // CPU writes: full word to 0xFF, byte lane 1 patch, full word to 0x00
      cpu_write = 1; cpu_address = 8'hFF; cpu_writedata = 32'hA5A55A5A; cpu_byteenable = 4'hF;
      to_check();
      chk("cpu_wr_wait", 32'(cpu_waitrequest), 32'd0);
      next_cyc();
      cpu_writedata = 32'h00003C00; cpu_byteenable = 4'b0010;
      next_cyc();
      cpu_address = 8'h00; cpu_writedata = 32'h0BADF00D; cpu_byteenable = 4'hF;
      next_cyc();
      cpu_write = 0;

      // Read at 0xFF via no_action_a, address wraps to 0
      jdo = jdo_a(1'b0, 8'hFF); strobes(1, 0, 0);
      next_cyc();
      strobes(0, 0, 1);
      next_cyc();
      strobes(0, 0, 0);
      repeat (2) next_cyc();
      to_check();
      chk("wrap_mond", MonDReg, 32'hA5A53C5A);
      chk("wrap_addr", 32'(dut.mon_a_q), 32'h00);
      chk("wrap_busy", 32'(ocimem_busy), 32'd0);
      next_cyc();

      // Overrun: second no_action_a in RD_ISSUE, action_a in RD_CAPTURE
      strobes(0, 0, 1);
      next_cyc();
      to_check();
      chk("ovr_before", 32'(ocimem_overrun), 32'd0);
      next_cyc();
      jdo = jdo_a(1'b0, 8'h40); strobes(1, 0, 0);
      to_check();
      chk("ovr_set", 32'(ocimem_overrun), 32'd1);
      chk("ovr_busy", 32'(ocimem_busy), 32'd1);
      next_cyc();
      strobes(0, 0, 0);
      to_check();
      chk("ovr_sticky", 32'(ocimem_overrun), 32'd1);
      chk("ovr_addr", 32'(dut.mon_a_q), 32'h01);
      chk("ovr_mond", MonDReg, 32'h0BADF00D);
      next_cyc();

      // Simultaneous action_a + action_b: action_a wins, clears overrun
      jdo = jdo_a(1'b0, 8'h10); strobes(1, 1, 0);
      next_cyc();
      strobes(0, 0, 0);
      to_check();
      chk("prio_overrun", 32'(ocimem_overrun), 32'd0);
      chk("prio_busy", 32'(ocimem_busy), 32'd0);
      chk("prio_addr", 32'(dut.mon_a_q), 32'h10);
      chk("prio_mond", MonDReg, 32'h0BADF00D);
      next_cyc();

      // Reset during RD_CAPTURE; CPU write during reset is ignored
      jdo = jdo_a(1'b1, 8'h10); strobes(1, 0, 0);
      next_cyc();
      strobes(0, 0, 0);
      next_cyc();
      reset_n = 0;
      cpu_write = 1; cpu_address = 8'h10; cpu_writedata = 32'h0; cpu_byteenable = 4'hF;
      to_check();
      chk("rstmid_busy", 32'(ocimem_busy), 32'd1);
      next_cyc();
      reset_n = 1; cpu_write = 0;
      to_check();
      chk("rstmid_idle", 32'(ocimem_busy), 32'd0);
      chk("rstmid_mond", MonDReg, 32'd0);
      chk("rstmid_addr", 32'(dut.mon_a_q), 32'd0);
      next_cyc();
      cpu_read = 1; cpu_address = 8'h10;
      to_check();
      chk("rstmid_cpu_grant", 32'(cpu_waitrequest), 32'd1);
      next_cyc();
      to_check();
      chk("rstmid_cpu_wait", 32'(cpu_waitrequest), 32'd0);
      chk("rstmid_ram_kept", cpu_readdata, 32'hDEADBEEF);
      next_cyc();
      cpu_read = 0;
      to_check();
      chk("idle_wait", 32'(cpu_waitrequest), 32'd0);
      next_cyc();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
